multicycle_ctrl: RTL and testbench

Main controller for the multicycle RV32I subset core; it drives the 4-bit ALU control and datapath mux/enable signals and consumes the ALU zero flag.
- Registered Moore FSM steps each instruction through fetch, decode, execute, memory and writeback; only the branch PC write is Mealy, on zero.
- Supported: lw, sw, R-type ALU, I-type ALU, beq, jal. Any other opcode traps to a sticky illegal state.

---
 rtl/multicycle_ctrl.sv | 177 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I-subset main controller: Moore FSM plus ALU funct decode.
// Optional macro CTRL_BNE_EN: accept bne (funct3=001) through the BEQ state.
module multicycle_ctrl #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [3:0] alu_control,
    output logic       illegal
);
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2,
        S_MEMREAD = 4'd3, S_MEMWB = 4'd4, S_MEMWRITE = 4'd5, S_EXECR = 4'd6,
        S_EXECI = 4'd7, S_ALUWB = 4'd8, S_BEQ = 4'd9, S_JAL = 4'd10, S_ILLEGAL = 4'd11;

    localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
        OP_I = 7'b0010011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
        ALU_XOR = 4'b0100, ALU_SLL = 4'b0101, ALU_SUB = 4'b0110, ALU_SLT = 4'b0111,
        ALU_SRA = 4'b1101;

    logic [3:0] r_state, w_next;
    logic [3:0] w_funct_alu;
    logic       w_funct_ok;
    logic       w_br_ok;
    logic       w_pc_write, w_mem_write, w_ir_write, w_reg_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= RESET_STATE;
        else        r_state <= w_next;
    end

    // funct3=101 with funct7b5=0 and funct3=011 clear w_funct_ok, so EXEC* traps.
    always_comb begin
        w_funct_alu = ALU_ADD;
        w_funct_ok  = 1'b1;
        case (funct3)
            3'b000:  w_funct_alu = (op == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_funct_alu = ALU_SLL;
            3'b010:  w_funct_alu = ALU_SLT;
            3'b100:  w_funct_alu = ALU_XOR;
            3'b110:  w_funct_alu = ALU_OR;
            3'b111:  w_funct_alu = ALU_AND;
            3'b101:  begin
                if (funct7b5) w_funct_alu = ALU_SRA;
                else          w_funct_ok  = 1'b0;
            end
            default: w_funct_ok = 1'b0;
        endcase
    end

`ifdef CTRL_BNE_EN
    assign w_br_ok = (funct3 == 3'b000) || (funct3 == 3'b001);
`else
    assign w_br_ok = (funct3 == 3'b000);
`endif

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BR:        w_next = w_br_ok ? S_BEQ : S_ILLEGAL;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  w_next = S_MEMWB;
            S_MEMWB:    w_next = S_FETCH;
            S_MEMWRITE: w_next = S_FETCH;
            S_EXECR,
            S_EXECI:    w_next = w_funct_ok ? S_ALUWB : S_ILLEGAL;
            S_ALUWB:    w_next = S_FETCH;
            S_BEQ:      w_next = S_FETCH;
            S_JAL:      w_next = S_ALUWB;
            S_ILLEGAL:  w_next = S_ILLEGAL;
            default:    w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_write  = 1'b0;
        w_mem_write = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        imm_src     = 2'b00;
        alu_control = ALU_AND;
        illegal     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_ir_write  = 1'b1;
                w_pc_write  = 1'b1;
                alu_src_b   = 2'b10;
                alu_control = ALU_ADD;
                result_src  = 2'b10;
            end
            S_DECODE: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b01;
                imm_src     = 2'b10;
                alu_control = ALU_ADD;
            end
            S_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                imm_src     = (op == OP_SW) ? 2'b01 : 2'b00;
                alu_control = ALU_ADD;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src  = 2'b01;
                w_reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a   = 2'b10;
                alu_control = w_funct_alu;
            end
            S_EXECI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                alu_control = w_funct_alu;
            end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BEQ: begin
                alu_src_a   = 2'b10;
                alu_control = ALU_SUB;
`ifdef CTRL_BNE_EN
                w_pc_write  = (funct3 == 3'b001) ? ~zero : zero;
`else
                w_pc_write  = zero;
`endif
            end
            // Link value OldPC+4 goes to ALUOut; jump target already sits there.
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                imm_src     = 2'b11;
                alu_control = ALU_ADD;
                w_pc_write  = 1'b1;
            end
            S_ILLEGAL:  illegal = 1'b1;
            default:    ;
        endcase
    end

    // Enables are masked while reset is held so nothing commits mid-abort.
    assign pc_write  = w_pc_write  & rst_n;
    assign mem_write = w_mem_write & rst_n;
    assign ir_write  = w_ir_write  & rst_n;
    assign reg_write = w_reg_write & rst_n;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction class state by state.
module tb_multicycle_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0] alu_control;
    logic [17:0] obs;
    int n_pass = 0;
    int n_total = 0;

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write), .adr_src(adr_src), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .result_src(result_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
        .alu_control(alu_control), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, A, B, imm, alu, illegal}
    assign obs = {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
                  alu_src_a, alu_src_b, imm_src, alu_control, illegal};

    localparam logic [17:0]
        V_RST    = {5'b00000, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0010, 1'b0},
        V_FETCH  = {5'b10010, 2'b10, 2'b00, 2'b10, 2'b00, 4'b0010, 1'b0},
        V_DECODE = {5'b00000, 2'b00, 2'b01, 2'b01, 2'b10, 4'b0010, 1'b0},
        V_MA_LW  = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0010, 1'b0},
        V_MA_SW  = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b01, 4'b0010, 1'b0},
        V_MEMRD  = {5'b01000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0},
        V_MEMWB  = {5'b00001, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0},
        V_MEMWR  = {5'b01100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0},
        V_XR_SUB = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0},
        V_XR_ADD = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0010, 1'b0},
        V_XI_ADD = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'b0010, 1'b0},
        V_XI_SRA = {5'b00000, 2'b00, 2'b10, 2'b01, 2'b00, 4'b1101, 1'b0},
        V_ALUWB  = {5'b00001, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0},
        V_BEQ_T  = {5'b10000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0},
        V_BEQ_N  = {5'b00000, 2'b00, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0},
        V_JAL    = {5'b10000, 2'b00, 2'b01, 2'b10, 2'b11, 4'b0010, 1'b0},
        V_ILL    = {5'b00000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1};

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        #2;
        if (obs !== V_RST) $display("FAIL reset_hold got=%h exp=%h", obs, V_RST);
        else n_pass++;
        n_total++;
        rst_n = 1'b1;
        #1;
        if (obs !== V_FETCH) $display("FAIL reset_release got=%h exp=%h", obs, V_FETCH);
        else n_pass++;
        n_total++;
    endtask

    task automatic test_lw;
        logic [17:0] e [6];
        e = '{V_FETCH, V_DECODE, V_MA_LW, V_MEMRD, V_MEMWB, V_FETCH};
        op = 7'b0000011;
        for (int i = 0; i < 6; i++) begin
            if (obs !== e[i]) $display("FAIL lw_cyc%0d got=%h exp=%h", i, obs, e[i]);
            else n_pass++;
            n_total++;
            if (i < 5) step();
        end
    endtask

    task automatic test_rtype;
        logic [17:0] e [5];
        op = 7'b0110011;
        funct3 = 3'b000;
        for (int k = 0; k < 2; k++) begin
            funct7b5 = (k == 0);
            e = '{V_FETCH, V_DECODE, (k == 0) ? V_XR_SUB : V_XR_ADD, V_ALUWB, V_FETCH};
            for (int i = 0; i < 5; i++) begin
                if (obs !== e[i]) $display("FAIL rtype%0d_cyc%0d got=%h exp=%h", k, i, obs, e[i]);
                else n_pass++;
                n_total++;
                if (i < 4) step();
            end
        end
    endtask

    task automatic test_itype;
        logic [17:0] e [5];
        op = 7'b0010011;
        funct7b5 = 1'b1;
        for (int k = 0; k < 2; k++) begin
            funct3 = (k == 0) ? 3'b000 : 3'b101;
            e = '{V_FETCH, V_DECODE, (k == 0) ? V_XI_ADD : V_XI_SRA, V_ALUWB, V_FETCH};
            for (int i = 0; i < 5; i++) begin
                if (obs !== e[i]) $display("FAIL itype%0d_cyc%0d got=%h exp=%h", k, i, obs, e[i]);
                else n_pass++;
                n_total++;
                if (i < 4) step();
            end
        end
    endtask

    task automatic test_beq;
        logic [17:0] e [4];
        op = 7'b1100011;
        funct3 = 3'b000;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            e = '{V_FETCH, V_DECODE, (k == 0) ? V_BEQ_T : V_BEQ_N, V_FETCH};
            for (int i = 0; i < 4; i++) begin
                if (obs !== e[i]) $display("FAIL beq_z%0d_cyc%0d got=%h exp=%h", zero, i, obs, e[i]);
                else n_pass++;
                n_total++;
                if (i < 3) step();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_jal;
        logic [17:0] e [5];
        e = '{V_FETCH, V_DECODE, V_JAL, V_ALUWB, V_FETCH};
        op = 7'b1101111;
        for (int i = 0; i < 5; i++) begin
            if (obs !== e[i]) $display("FAIL jal_cyc%0d got=%h exp=%h", i, obs, e[i]);
            else n_pass++;
            n_total++;
            if (i < 4) step();
        end
    endtask

    task automatic test_reset_mid;
        logic [17:0] e [4];
        e = '{V_FETCH, V_DECODE, V_MA_SW, V_MEMWR};
        op = 7'b0100011;
        for (int i = 0; i < 4; i++) begin
            if (obs !== e[i]) $display("FAIL sw_cyc%0d got=%h exp=%h", i, obs, e[i]);
            else n_pass++;
            n_total++;
            if (i < 3) step();
        end
        rst_n = 1'b0;
        #1;
        if (obs !== V_RST) $display("FAIL sw_abort got=%h exp=%h", obs, V_RST);
        else n_pass++;
        n_total++;
        step();
        if (obs !== V_RST) $display("FAIL sw_abort_edge got=%h exp=%h", obs, V_RST);
        else n_pass++;
        n_total++;
        rst_n = 1'b1;
        #1;
        if (obs !== V_FETCH) $display("FAIL sw_recover got=%h exp=%h", obs, V_FETCH);
        else n_pass++;
        n_total++;
    endtask

    // Three trap cases: bad opcode, srli, bne (accepted only with CTRL_BNE_EN).
    task automatic test_illegal;
        logic [17:0] e [5];
        for (int k = 0; k < 3; k++) begin
            zero = 1'b0;
            funct7b5 = 1'b0;
            case (k)
                0: begin op = 7'b0000000; funct3 = 3'b000;
                   e = '{V_FETCH, V_DECODE, V_ILL, V_ILL, V_ILL}; end
                1: begin op = 7'b0010011; funct3 = 3'b101;
                   e = '{V_FETCH, V_DECODE, V_XI_ADD, V_ILL, V_ILL}; end
                default: begin op = 7'b1100011; funct3 = 3'b001;
`ifdef CTRL_BNE_EN
                   e = '{V_FETCH, V_DECODE, V_BEQ_T, V_FETCH, V_DECODE};
`else
                   e = '{V_FETCH, V_DECODE, V_ILL, V_ILL, V_ILL};
`endif
                end
            endcase
            for (int i = 0; i < 5; i++) begin
                if (obs !== e[i]) $display("FAIL trap%0d_cyc%0d got=%h exp=%h", k, i, obs, e[i]);
                else n_pass++;
                n_total++;
                if (i < 4) step();
            end
            do_reset();
            if (obs !== V_FETCH) $display("FAIL trap%0d_clear got=%h exp=%h", k, obs, V_FETCH);
            else n_pass++;
            n_total++;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_rtype();
        test_itype();
        test_beq();
        test_jal();
        test_reset_mid();
        test_illegal();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
